// File: rtl/bfly_round_sat_ser.sv
// rtl/bfly_round_sat_ser.sv - butterfly round-half-up/saturate, pair FIFO, p/q serializer; optional BFLY_SAT_CNT_EN adds sat_cnt
module bfly_round_sat_ser #(
    parameter int IN_WIDTH  = 44,
    parameter int SHIFT     = 15,
    parameter int OUT_WIDTH = 28,
    parameter int DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  yp_r,
    input  logic signed [IN_WIDTH-1:0]  yp_i,
    input  logic signed [IN_WIDTH-1:0]  yq_r,
    input  logic signed [IN_WIDTH-1:0]  yq_i,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_r,
    output logic signed [OUT_WIDTH-1:0] out_i,
    output logic                        out_is_q,
    input  logic                        sat_clr,
    output logic                        sat_flag
`ifdef BFLY_SAT_CNT_EN
    ,
    output logic [15:0]                 sat_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    // width of the rounded value before clamping; assumed >= OUT_WIDTH
    localparam int SW = IN_WIDTH + 1 - SHIFT;
    localparam int EW = 4 * OUT_WIDTH;

    localparam logic signed [IN_WIDTH:0] HALF = (IN_WIDTH+1)'(1) << (SHIFT - 1);
    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Returns {saturated, value}: add half an LSB one bit wider than the
    // input so the bias never wraps, drop SHIFT bits (floor), then clamp.
    function automatic logic [OUT_WIDTH:0] round_sat(input logic signed [IN_WIDTH-1:0] x);
        logic signed [IN_WIDTH:0] v;
        logic signed [SW-1:0]     s;
        v = $signed({x[IN_WIDTH-1], x}) + HALF;
        s = v[IN_WIDTH:SHIFT];
        if (s > SAT_MAX) begin
            round_sat = {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
        end else if (s < SAT_MIN) begin
            round_sat = {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
        end else begin
            round_sat = {1'b0, s[OUT_WIDTH-1:0]};
        end
    endfunction

    logic [OUT_WIDTH:0] rs_pr;
    logic [OUT_WIDTH:0] rs_pi;
    logic [OUT_WIDTH:0] rs_qr;
    logic [OUT_WIDTH:0] rs_qi;
    logic               any_sat;
    logic [EW-1:0]      in_word;

    assign rs_pr   = round_sat(yp_r);
    assign rs_pi   = round_sat(yp_i);
    assign rs_qr   = round_sat(yq_r);
    assign rs_qi   = round_sat(yq_i);
    assign any_sat = rs_pr[OUT_WIDTH] | rs_pi[OUT_WIDTH] | rs_qr[OUT_WIDTH] | rs_qi[OUT_WIDTH];
    assign in_word = {rs_pr[OUT_WIDTH-1:0], rs_pi[OUT_WIDTH-1:0],
                      rs_qr[OUT_WIDTH-1:0], rs_qi[OUT_WIDTH-1:0]};

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_nxt;
    logic [PW-1:0] rd_nxt;
    logic          phase;
    logic          push;
    logic          pop;
    logic          full_nxt;
    logic [EW-1:0] head;

    // in_ready is the registered !full, so a pop never frees a slot for a
    // push in the same cycle
    assign push     = in_valid && in_ready;
    assign out_valid = (wr_ptr != rd_ptr);
    assign pop      = out_valid && out_ready && phase;
    assign wr_nxt   = wr_ptr + PW'(push);
    assign rd_nxt   = rd_ptr + PW'(pop);
    assign full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);

    // Pointer, phase, ready and sticky saturation state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            phase    <= 1'b0;
            in_ready <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            in_ready <= !full_nxt;
            if (out_valid && out_ready) begin
                phase <= !phase;
            end
            if (push && any_sat) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset because outputs are gated by out_valid
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr[AW-1:0]] <= in_word;
        end
    end

    // Head entry muxed by phase; zero whenever nothing is buffered
    assign head     = mem[rd_ptr[AW-1:0]];
    assign out_is_q = phase;
    assign out_r    = !out_valid ? '0 :
                      (phase ? head[2*OUT_WIDTH-1:OUT_WIDTH] : head[4*OUT_WIDTH-1:3*OUT_WIDTH]);
    assign out_i    = !out_valid ? '0 :
                      (phase ? head[OUT_WIDTH-1:0] : head[3*OUT_WIDTH-1:2*OUT_WIDTH]);

`ifdef BFLY_SAT_CNT_EN
    logic sat_inc;
    assign sat_inc = push && any_sat;

    // Saturating count of accepted pairs that clipped; clear with a
    // coincident increment leaves exactly one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= sat_inc ? 16'd1 : 16'd0;
        end else if (sat_inc && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bfly_round_sat_ser.sv
// tb/tb_bfly_round_sat_ser.sv - directed and scoreboard bench for bfly_round_sat_ser
module tb_bfly_round_sat_ser;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [43:0] yp_r;
    logic signed [43:0] yp_i;
    logic signed [43:0] yq_r;
    logic signed [43:0] yq_i;
    logic               out_valid;
    logic               out_ready;
    logic signed [27:0] out_r;
    logic signed [27:0] out_i;
    logic               out_is_q;
    logic               sat_clr;
    logic               sat_flag;
`ifdef BFLY_SAT_CNT_EN
    logic [15:0]        sat_cnt;
`endif

    int tests = 0;
    int fails = 0;

    longint exp_r [$];
    longint exp_i [$];
    longint exp_q [$];
    int     acc;
    int     emitted;

    bfly_round_sat_ser dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .yp_r     (yp_r),
        .yp_i     (yp_i),
        .yq_r     (yq_r),
        .yq_i     (yq_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r    (out_r),
        .out_i    (out_i),
        .out_is_q (out_is_q),
        .sat_clr  (sat_clr),
        .sat_flag (sat_flag)
`ifdef BFLY_SAT_CNT_EN
        ,
        .sat_cnt  (sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint model(input longint x);
        longint v;
        v = (x + 64'sd16384) >>> 15;
        if (v > 64'sd134217727) v = 64'sd134217727;
        if (v < -64'sd134217728) v = -64'sd134217728;
        return v;
    endfunction

    task automatic set_pair(input longint a, input longint b, input longint c, input longint d);
        yp_r = a[43:0];
        yp_i = b[43:0];
        yq_r = c[43:0];
        yq_i = d[43:0];
    endtask

    task automatic sb_cycle(input bit iv, input bit ordy,
                            input longint a, input longint b, input longint c, input longint d);
        in_valid  = iv;
        out_ready = ordy;
        set_pair(a, b, c, d);
        if (iv && in_ready) begin
            exp_r.push_back(model(a)); exp_i.push_back(model(b)); exp_q.push_back(0);
            exp_r.push_back(model(c)); exp_i.push_back(model(d)); exp_q.push_back(1);
            acc++;
        end
        if (out_valid && ordy) begin
            if (exp_r.size() == 0) begin
                chk("sb_unexpected_sample", 1, 0);
            end else begin
                chk("sb_out_r", out_r, exp_r.pop_front());
                chk("sb_out_i", out_i, exp_i.pop_front());
                chk("sb_out_is_q", out_is_q, exp_q.pop_front());
            end
            emitted++;
        end
        step();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (!out_valid) break;
            step();
        end
        chk("drain_empty", out_valid, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        longint ra, rb, rc, rd;
        longint tmp;
        int     acc_mark;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
        set_pair(0, 0, 0, 0);

        // reset state
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_i", out_i, 0);
        chk("rst_out_is_q", out_is_q, 0);
        chk("rst_sat_flag", sat_flag, 0);
`ifdef BFLY_SAT_CNT_EN
        chk("rst_sat_cnt", sat_cnt, 0);
`endif
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);

        // rounding, including a tie toward +inf
        set_pair(114688, -16384, -16385, 16383);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rnd_valid", out_valid, 1);
        chk("rnd_p_r", out_r, 4);
        chk("rnd_p_i", out_i, 0);
        chk("rnd_p_isq", out_is_q, 0);
        out_ready = 1'b1;
        step();
        chk("rnd_q_r", out_r, -1);
        chk("rnd_q_i", out_i, 0);
        chk("rnd_q_isq", out_is_q, 1);
        step();
        chk("rnd_empty", out_valid, 0);
        chk("rnd_sat_flag", sat_flag, 0);
        out_ready = 1'b0;

        // saturating input that is not accepted is ignored
        set_pair(64'sd1 <<< 42, 0, 0, -(64'sd1 <<< 43));
        step();
        chk("sat_ignored_flag", sat_flag, 0);

        // saturation
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("sat_flag_set", sat_flag, 1);
        chk("sat_p_r", out_r, 134217727);
`ifdef BFLY_SAT_CNT_EN
        chk("sat_cnt_1", sat_cnt, 1);
`endif
        out_ready = 1'b1;
        step();
        chk("sat_q_i", out_i, -134217728);
        chk("sat_q_isq", out_is_q, 1);
        drain();

        // clear and new saturation in the same cycle: set wins
        sat_clr = 1'b1; in_valid = 1'b1;
        step();
        sat_clr = 1'b0; in_valid = 1'b0;
        chk("sat_set_wins", sat_flag, 1);
`ifdef BFLY_SAT_CNT_EN
        chk("sat_cnt_clr_inc", sat_cnt, 1);
`endif
        drain();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("sat_cleared", sat_flag, 0);
`ifdef BFLY_SAT_CNT_EN
        chk("sat_cnt_cleared", sat_cnt, 0);
`endif

        // backpressure: 5 offered, 4 accepted
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            set_pair((10*k+1)*32768, (10*k+2)*32768, (10*k+3)*32768, (10*k+4)*32768);
            in_valid = 1'b1;
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 4);
        chk("bp_in_ready_low", in_ready, 0);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("bp_stall_r", out_r, 1);
            chk("bp_stall_i", out_i, 2);
            chk("bp_stall_isq", out_is_q, 0);
        end
        out_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_r", out_r, 10*(s/2) + 1 + 2*(s%2));
            chk("bp_i", out_i, 10*(s/2) + 2 + 2*(s%2));
            chk("bp_isq", out_is_q, s%2);
            step();
        end
        chk("bp_done", out_valid, 0);
        out_ready = 1'b0;

        // streaming with a counter pattern
        acc = 0; emitted = 0; acc_mark = 0;
        for (int n = 0; n < 60; n++) begin
            if (n == 40) acc_mark = acc;
            if (n >= 1) chk("stream_sustained", out_valid, 1);
            sb_cycle(1'b1, 1'b1, longint'(acc)*32768, -longint'(acc)*32768 - 16384,
                     longint'(acc)*40000, -longint'(acc)*50000);
        end
        chk("stream_samples", emitted, 59);
        chk("stream_half_rate", acc - acc_mark, 10);
        for (int n = 0; n < 40 && exp_r.size() != 0; n++) begin
            sb_cycle(1'b0, 1'b1, 0, 0, 0, 0);
        end
        chk("stream_sb_empty", exp_r.size(), 0);
        chk("stream_out_idle", out_valid, 0);

        // random stalls against the model
        acc = 0; emitted = 0;
        for (int n = 0; n < 20000 && acc < 1000; n++) begin
            tmp = {$urandom(), $urandom()}; ra = tmp >>> $urandom_range(20, 50);
            tmp = {$urandom(), $urandom()}; rb = tmp >>> $urandom_range(20, 50);
            tmp = {$urandom(), $urandom()}; rc = tmp >>> $urandom_range(20, 50);
            tmp = {$urandom(), $urandom()}; rd = tmp >>> $urandom_range(20, 50);
            sb_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb, rc, rd);
        end
        chk("rand_pairs_accepted", acc, 1000);
        for (int n = 0; n < 40 && exp_r.size() != 0; n++) begin
            sb_cycle(1'b0, 1'b1, 0, 0, 0, 0);
        end
        chk("rand_sb_empty", exp_r.size(), 0);
        out_ready = 1'b0;

        // reset with three pairs buffered (one saturating)
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_pair((k == 1) ? (64'sd1 <<< 42) : 32768*(k+20), 0, 0, 0);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_sat_flag", sat_flag, 1);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sat_flag", sat_flag, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("after_rst_valid", out_valid, 0);
        chk("after_rst_out_r", out_r, 0);
        set_pair(7*32768, 8*32768, 9*32768, 10*32768);
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("after_rst_p_r", out_r, 7);
        chk("after_rst_p_i", out_i, 8);
        chk("after_rst_isq", out_is_q, 0);
        out_ready = 1'b1;
        step();
        chk("after_rst_q_r", out_r, 9);
        chk("after_rst_q_i", out_i, 10);
        step();
        chk("after_rst_empty", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
